// File: rtl/mem_if_pkg.sv
// Shared data-memory interface definitions: default widths, responder FSM states
// and the CEN/WEN/OEN access decode used on both sides of the interface.
package mem_if_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_e;

    // Strobes are active low
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } mem_acc_e;

    // A write strobe dominates a simultaneous output enable
    function automatic mem_acc_e decode_access(input logic cen, input logic wen, input logic oen);
        mem_acc_e acc;
        acc = ACC_NONE;
        if (cen == STROBE_ON) begin
            if (wen == STROBE_ON) begin
                acc = ACC_WRITE;
            end else if (oen == STROBE_ON) begin
                acc = ACC_READ;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-data delay line: LAT stages of valid/data with synchronous flush.
// LAT=0 degenerates to a straight wire.
module mem_rd_pipe #(
    parameter int LAT = 0,
    parameter int W   = 32
) (
    input  logic         clk,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    generate
        if (LAT == 0) begin : g_wire
            logic unused_pipe_ctl;
            assign unused_pipe_ctl = clk ^ flush;
            assign out_valid       = in_valid;
            assign out_data        = in_data;
        end else begin : g_pipe
            logic [LAT-1:0] vld;
            logic [W-1:0]   dat [LAT];

            always_ff @(posedge clk) begin
                if (flush) begin
                    vld <= '0;
                    for (int i = 0; i < LAT; i++) begin
                        dat[i] <= '0;
                    end
                end else begin
                    vld[0] <= in_valid;
                    dat[0] <= in_data;
                    for (int i = 1; i < LAT; i++) begin
                        vld[i] <= vld[i-1];
                        dat[i] <= dat[i-1];
                    end
                end
            end

            assign out_valid = vld[LAT-1];
            assign out_data  = dat[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the core data interface: zero-filling word store,
// configurable read latency, bench load/dump side port and saturating access counters.
//   state    | meaning
//   ST_CLEAR | sweeping mem[ptr] <= 0, core ignored, side port closed
//   ST_READY | normal operation until the next reset
module data_mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              CEN,
    input  logic              WEN,
    input  logic              OEN,
    input  logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] D,
    output logic [DATA_W-1:0] Q,
    output logic              busy,
    output logic              prot_err,
    input  logic              ld_valid,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ready,
    output logic [DATA_W-1:0] ld_rdata,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  wr_cnt
);

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    mem_state_e        state_q;
    mem_state_e        state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    mem_acc_e          acc;
    logic              live;
    logic              core_wr;
    logic              core_rd;
    logic              core_show;
    logic              ld_fire;
    logic [DATA_W-1:0] rd_word;
    logic              pipe_in_valid;
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;
    logic [DATA_W-1:0] q_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                busy = 1'b1;
                if (ptr_q == PTR_LAST) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // Reset dominates: nothing is accepted in a cycle where rst is high
    assign acc       = decode_access(CEN, WEN, OEN);
    assign live      = (state_q == ST_READY) && !rst;
    assign core_wr   = live && (acc == ACC_WRITE);
    assign core_rd   = live && (acc == ACC_READ);
    assign core_show = live && (CEN == STROBE_ON) && (OEN == STROBE_ON);
    assign ld_ready  = live && (CEN == STROBE_OFF);
    assign ld_fire   = ld_valid && ld_ready;
    assign rd_word   = mem[A];

    // Combinational Q also shows the pre-write word on a write/read collision
    assign pipe_in_valid = (RD_LAT == 0) ? core_show : core_rd;

    mem_rd_pipe #(
        .LAT (RD_LAT),
        .W   (DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .flush     (rst),
        .in_valid  (pipe_in_valid),
        .in_data   (rd_word),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    assign Q = pipe_valid ? pipe_data : q_hold;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem[ptr_q] <= '0;
            end else if (core_wr) begin
                mem[A] <= D;
            end else if (ld_fire && ld_we) begin
                mem[ld_addr] <= ld_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q    <= '0;
            prot_err <= 1'b0;
            ld_rdata <= '0;
            q_hold   <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
        end else begin
            if (state_q == ST_CLEAR) begin
                ptr_q <= ptr_q + PTR_ONE;
            end
            prot_err <= (state_q == ST_CLEAR) && (CEN == STROBE_ON);
            if (ld_fire && !ld_we) begin
                ld_rdata <= mem[ld_addr];
            end
            if (pipe_valid) begin
                q_hold <= pipe_data;
            end
            if (core_rd && (rd_cnt != CNT_MAX)) begin
                rd_cnt <= rd_cnt + CNT_ONE;
            end
            if (core_wr && (wr_cnt != CNT_MAX)) begin
                wr_cnt <= wr_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: three instances (latency 0, 2 and 3,
// the last with 2-bit counters) share one stimulus stream and a queue-based reference model.
module tb_data_mem_responder;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cen = 1'b1;
    logic          wen = 1'b1;
    logic          oen = 1'b1;
    logic [AW-1:0] a = '0;
    logic [DW-1:0] d = '0;
    logic          ld_valid = 1'b0;
    logic          ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_wdata = '0;

    logic [DW-1:0] q0, q2, q3, ldr0, ldr2, ldr3;
    logic          busy0, busy2, busy3, prot0, prot2, prot3, ldy0, ldy2, ldy3;
    logic [15:0]   rdc0, wrc0, rdc2, wrc2;
    logic [1:0]    rdc3, wrc3;

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(0), .CNT_W(16)) u0 (
        .clk(clk), .rst(rst), .CEN(cen), .WEN(wen), .OEN(oen), .A(a), .D(d), .Q(q0),
        .busy(busy0), .prot_err(prot0), .ld_valid(ld_valid), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ready(ldy0), .ld_rdata(ldr0),
        .rd_cnt(rdc0), .wr_cnt(wrc0));

    data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .CEN(cen), .WEN(wen), .OEN(oen), .A(a), .D(d), .Q(q2),
        .busy(busy2), .prot_err(prot2), .ld_valid(ld_valid), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ready(ldy2), .ld_rdata(ldr2),
        .rd_cnt(rdc2), .wr_cnt(wrc2));

    data_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .CNT_W(2)) u3 (
        .clk(clk), .rst(rst), .CEN(cen), .WEN(wen), .OEN(oen), .A(a), .D(d), .Q(q3),
        .busy(busy3), .prot_err(prot3), .ld_valid(ld_valid), .ld_we(ld_we),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ready(ldy3), .ld_rdata(ldr3),
        .rd_cnt(rdc3), .wr_cnt(wrc3));

    int n_err = 0;
    int n_chk = 0;

    // Reference model: word array, sweep countdown, reads as timestamped queue entries
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } pend_t;

    logic [DW-1:0] mem_m [128];
    bit            ready_m = 1'b0;
    int            clr_m = 0;
    bit            prot_m = 1'b0;
    logic [DW-1:0] ldr_m = '0;
    logic [DW-1:0] q0h_m = '0;
    logic [DW-1:0] q2_m = '0;
    logic [DW-1:0] q3_m = '0;
    int            rdc_m = 0;
    int            wrc_m = 0;
    int            edge_n = 0;
    pend_t         p2[$];
    pend_t         p3[$];

    typedef struct {
        logic          cen, wen, oen;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_q0;
        logic [DW-1:0] exp_q2;
    } vec_t;

    vec_t          tbl[14];
    bit            tbl_on = 1'b0;
    logic [DW-1:0] tbl_q0 = '0;
    logic [DW-1:0] tbl_q2 = '0;

    function automatic logic [31:0] sat(input int v, input int mx);
        return (v > mx) ? 32'(mx) : 32'(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [DW-1:0] q0_exp;
        q0_exp = (ready_m && !cen && !oen) ? mem_m[a] : q0h_m;
        chk("busy0", 32'(busy0), 32'(!ready_m));
        chk("busy2", 32'(busy2), 32'(!ready_m));
        chk("busy3", 32'(busy3), 32'(!ready_m));
        chk("prot0", 32'(prot0), 32'(prot_m));
        chk("prot3", 32'(prot3), 32'(prot_m));
        chk("ld_ready0", 32'(ldy0), 32'(ready_m && cen));
        chk("ld_ready2", 32'(ldy2), 32'(ready_m && cen));
        chk("ld_rdata0", ldr0, ldr_m);
        chk("ld_rdata3", ldr3, ldr_m);
        chk("q_lat0", q0, q0_exp);
        chk("q_lat2", q2, q2_m);
        chk("q_lat3", q3, q3_m);
        chk("rd_cnt0", 32'(rdc0), sat(rdc_m, 65535));
        chk("wr_cnt0", 32'(wrc0), sat(wrc_m, 65535));
        chk("rd_cnt2", 32'(rdc2), sat(rdc_m, 65535));
        chk("rd_cnt3", 32'(rdc3), sat(rdc_m, 3));
        chk("wr_cnt3", 32'(wrc3), sat(wrc_m, 3));
        if (tbl_on) begin
            chk("tbl_q0", q0, tbl_q0);
            chk("tbl_q2", q2, tbl_q2);
        end
    endtask

    task automatic model_edge();
        bit    core, rd, wr, show;
        pend_t e;
        if (rst) begin
            foreach (mem_m[i]) mem_m[i] = '0;
            ready_m = 1'b0;
            clr_m   = 0;
            prot_m  = 1'b0;
            ldr_m   = '0;
            q0h_m   = '0;
            q2_m    = '0;
            q3_m    = '0;
            rdc_m   = 0;
            wrc_m   = 0;
            p2.delete();
            p3.delete();
        end else begin
            core   = !cen;
            wr     = ready_m && core && !wen;
            rd     = ready_m && core && wen && !oen;
            show   = ready_m && core && !oen;
            prot_m = core && !ready_m;
            while (p2.size() > 0 && p2[0].due == edge_n) begin
                q2_m = p2[0].data;
                void'(p2.pop_front());
            end
            while (p3.size() > 0 && p3[0].due == edge_n) begin
                q3_m = p3[0].data;
                void'(p3.pop_front());
            end
            if (show) q0h_m = mem_m[a];
            if (rd) begin
                e.data = mem_m[a];
                e.due  = edge_n + 1;
                p2.push_back(e);
                e.due  = edge_n + 2;
                p3.push_back(e);
                rdc_m++;
            end
            if (wr) begin
                mem_m[a] = d;
                wrc_m++;
            end
            if (ready_m && cen && ld_valid) begin
                if (ld_we) mem_m[ld_addr] = ld_wdata;
                else       ldr_m = mem_m[ld_addr];
            end
            if (!ready_m) begin
                clr_m++;
                if (clr_m == 128) ready_m = 1'b1;
            end
        end
        edge_n++;
    endtask

    // One clock: check at the falling edge, advance the model at the rising edge
    task automatic tick();
        @(negedge clk);
        if (!rst) check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        cen = 1'b1; wen = 1'b1; oen = 1'b1; ld_valid = 1'b0;
    endtask

    task automatic sweep_measure(input bit poke);
        int n;
        n = 0;
        while (busy0 && n < 200) begin
            idle();
            if (poke && n == 10) begin
                cen = 1'b0; wen = 1'b0; a = 7'd7; d = 32'hDEAD_BEEF;
            end
            if (poke && n >= 20 && n <= 30) begin
                ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 7'd64; ld_wdata = 32'h77;
            end
            tick();
            if (poke && n == 10) chk("prot_pulse", 32'(prot0), 32'd1);
            if (poke && n == 11) chk("prot_single", 32'(prot0), 32'd0);
            n++;
        end
        idle();
        chk("busy_cycles", 32'(n), 32'd128);
    endtask

    task automatic side_rd(input logic [AW-1:0] addr, input logic [DW-1:0] exp);
        idle();
        ld_valid = 1'b1; ld_we = 1'b0; ld_addr = addr;
        tick();
        ld_valid = 1'b0;
        chk("side_read", ldr0, exp);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 7'd5, 32'h3F80_0000, 32'h0,         32'h0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 7'd5, 32'h0,         32'h3F80_0000, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 7'd0, 32'h0,         32'h3F80_0000, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 7'd9, 32'hAA,        32'h3F80_0000, 32'h3F80_0000};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 7'd9, 32'hBB,        32'hAA,        32'h3F80_0000};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 7'd9, 32'h0,         32'hBB,        32'h3F80_0000};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 7'd1, 32'h11,        32'hBB,        32'h3F80_0000};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 7'd2, 32'h22,        32'hBB,        32'hBB};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 7'd3, 32'h33,        32'hBB,        32'hBB};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 7'd1, 32'h0,         32'h11,        32'hBB};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 7'd2, 32'h0,         32'h22,        32'hBB};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 7'd3, 32'h0,         32'h33,        32'h11};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 7'd0, 32'h0,         32'h33,        32'h22};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 7'd0, 32'h0,         32'h33,        32'h33};

        // Reset, then the zero-fill sweep with a stray core access and a refused side write
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("reset_q0", q0, 32'h0);
        chk("reset_cnt", 32'(rdc0) | 32'(wrc0), 32'h0);
        sweep_measure(1'b1);
        side_rd(7'd0, 32'h0);
        side_rd(7'd64, 32'h0);
        side_rd(7'd127, 32'h0);
        side_rd(7'd7, 32'h0);

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            cen = tbl[i].cen; wen = tbl[i].wen; oen = tbl[i].oen;
            a = tbl[i].a; d = tbl[i].d; ld_valid = 1'b0;
            tbl_q0 = tbl[i].exp_q0;
            tbl_q2 = tbl[i].exp_q2;
            tbl_on = 1'b1;
            tick();
            if (i == 1) begin
                chk("wr_cnt_after_first", 32'(wrc0), 32'd1);
                chk("rd_cnt_after_first", 32'(rdc0), 32'd1);
            end
        end
        tbl_on = 1'b0;
        idle();
        chk("wr_cnt_table", 32'(wrc0), 32'd6);
        chk("rd_cnt_table", 32'(rdc0), 32'd5);
        chk("rd_cnt_sat", 32'(rdc3), 32'd3);
        chk("wr_cnt_sat", 32'(wrc3), 32'd3);
        side_rd(7'd9, 32'hBB);

        // Side write held off by core traffic, accepted once CEN releases
        cen = 1'b0; wen = 1'b1; oen = 1'b0; a = 7'd5;
        ld_valid = 1'b1; ld_we = 1'b1; ld_addr = 7'd20; ld_wdata = 32'h55;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ld_ready_blocked", 32'(ldy0), 32'd0);
            tick();
        end
        cen = 1'b1;
        #1;
        chk("ld_ready_open", 32'(ldy0), 32'd1);
        tick();
        side_rd(7'd20, 32'h55);
        for (int i = 0; i < 3; i++) begin
            cen = 1'b0; wen = 1'b1; oen = 1'b0; a = 7'd20;
            tick();
        end
        idle();
        chk("rd_cnt_more", 32'(rdc0), 32'd10);
        chk("rd_cnt_sat_hold", 32'(rdc3), 32'd3);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            cen      = ($urandom_range(0, 2) == 0);
            wen      = 1'($urandom_range(0, 1));
            oen      = 1'($urandom_range(0, 1));
            a        = 7'($urandom_range(0, 15));
            d        = $urandom;
            ld_valid = 1'($urandom_range(0, 1));
            ld_we    = 1'($urandom_range(0, 1));
            ld_addr  = 7'($urandom_range(0, 15));
            ld_wdata = $urandom;
            tick();
        end
        idle();

        // Reset landing on an in-flight latency-3 read: that read must never surface
        cen = 1'b0; wen = 1'b0; oen = 1'b1; a = 7'd30; d = 32'hCAFE_F00D;
        tick();
        cen = 1'b0; wen = 1'b1; oen = 1'b0; a = 7'd30;
        tick();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("rst_flush_q3", q3, 32'h0);
            tick();
        end

        // Reset mid-sweep restarts the full sweep
        for (int i = 0; i < 44; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep_measure(1'b0);
        side_rd(7'd30, 32'h0);
        chk("q3_after_sweep", q3, 32'h0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
